btn_press_classifier: RTL

//  Consumer end of the button debouncer interface. Takes the clean, synchronous

---
 rtl/btn_press_classifier.sv | 125 ++++++++++++
 1 files changed

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: turns a debounced button level into single-cycle
// short-press, long-press and double-click pulses.
// Optional feature macro: BTN_REPEAT_EN enables auto-repeat pulses on o_repeat
// while the button is long-held; without it o_repeat is constant 0.
module btn_press_classifier #(
    parameter int LONG_CNT   = 50_000_000,
    parameter int GAP_CNT    = 25_000_000,
    parameter int REPEAT_CNT = 10_000_000,
    parameter int CNT_W      = $clog2((LONG_CNT > GAP_CNT)
                                 ? ((LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT)
                                 : ((GAP_CNT  > REPEAT_CNT) ? GAP_CNT  : REPEAT_CNT)) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_short,
    output logic o_long,
    output logic o_double,
    output logic o_repeat,
    output logic o_busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_WAIT_GAP  = 3'd2,
        S_PRESS2    = 3'd3,
        S_LONG_HELD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);
`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_btn_q;
    logic             w_rise;
    logic             w_short;
    logic             w_long;
    logic             w_double;
    logic             w_repeat;

    // r_btn_q resets to 1 so a button held through reset never looks like a fresh press.
    assign w_rise    = i_btn & ~r_btn_q;
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Next-state, counter and event decode; a release always beats a coincident threshold.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_double    = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_state_nxt = S_PRESS1;
            end
            S_PRESS1: begin
                if (!i_btn) begin
                    w_state_nxt = S_WAIT_GAP;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nxt = S_LONG_HELD;
                    w_long      = 1'b1;
                end
            end
            S_WAIT_GAP: begin
                if (i_btn) begin
                    w_state_nxt = S_PRESS2;
                end else if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_short     = 1'b1;
                end
            end
            S_PRESS2: begin
                if (!i_btn) begin
                    w_state_nxt = S_IDLE;
                    w_double    = 1'b1;
                end
            end
            S_LONG_HELD: begin
                if (!i_btn) begin
                    w_state_nxt = S_IDLE;
`ifdef BTN_REPEAT_EN
                end else if (r_cnt == REPEAT_LAST) begin
                    w_repeat  = 1'b1;
                    w_cnt_nxt = '0;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // State, counter, edge-detect history and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_btn_q  <= 1'b1;
            o_short  <= 1'b0;
            o_long   <= 1'b0;
            o_double <= 1'b0;
            o_repeat <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_btn_q  <= i_btn;
            o_short  <= w_short;
            o_long   <= w_long;
            o_double <= w_double;
            o_repeat <= w_repeat;
            o_busy   <= (w_state_nxt != S_IDLE);
        end
    end

endmodule
